multicycle_ctrl_fsm: RTL and testbench

MULTICYCLE_CTRL_FSM -- requirements
Module: multicycle_ctrl_fsm

---
 rtl/mc_ctrl_pkg.sv | 65 ++++++
 rtl/mem_wait_timer.sv | 38 +++
 rtl/multicycle_ctrl_fsm.sv | 217 +++++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mc_ctrl_pkg
//  Description : Opcodes, state encodings and datapath select encodings
//                shared by the multicycle controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package mc_ctrl_pkg;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_JAL   = 6'b000011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_BNE   = 6'b000101;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_SLTI  = 6'b001010;
    localparam logic [5:0] c_OP_ANDI  = 6'b001100;
    localparam logic [5:0] c_OP_ORI   = 6'b001101;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;

    localparam logic [3:0] c_ST_FETCH  = 4'd0;
    localparam logic [3:0] c_ST_DECODE = 4'd1;
    localparam logic [3:0] c_ST_MEMADR = 4'd2;
    localparam logic [3:0] c_ST_MEMRD  = 4'd3;
    localparam logic [3:0] c_ST_MEMWB  = 4'd4;
    localparam logic [3:0] c_ST_MEMWR  = 4'd5;
    localparam logic [3:0] c_ST_EXEC   = 4'd6;
    localparam logic [3:0] c_ST_ALUWB  = 4'd7;
    localparam logic [3:0] c_ST_BRANCH = 4'd8;
    localparam logic [3:0] c_ST_IEXEC  = 4'd9;
    localparam logic [3:0] c_ST_IWB    = 4'd10;
    localparam logic [3:0] c_ST_JUMP   = 4'd11;
    localparam logic [3:0] c_ST_JAL    = 4'd12;
    localparam logic [3:0] c_ST_TRAP   = 4'd13;

    localparam logic [1:0] c_PCSRC_ALU    = 2'b00;
    localparam logic [1:0] c_PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] c_PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] c_SRCB_RT      = 2'b00;
    localparam logic [1:0] c_SRCB_FOUR    = 2'b01;
    localparam logic [1:0] c_SRCB_IMM     = 2'b10;
    localparam logic [1:0] c_SRCB_IMM_SL2 = 2'b11;

    localparam logic [1:0] c_ALUOP_ADD   = 2'b00;
    localparam logic [1:0] c_ALUOP_SUB   = 2'b01;
    localparam logic [1:0] c_ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] c_ALUOP_IMM   = 2'b11;

    localparam logic [1:0] c_REGDST_RT = 2'b00;
    localparam logic [1:0] c_REGDST_RD = 2'b01;
    localparam logic [1:0] c_REGDST_RA = 2'b10;

    localparam logic [1:0] c_MEMTOREG_ALU = 2'b00;
    localparam logic [1:0] c_MEMTOREG_MEM = 2'b01;
    localparam logic [1:0] c_MEMTOREG_PC  = 2'b10;

    // Logical immediates use a zero-extended immediate.
    function automatic logic is_zext_op(input logic [5:0] op);
        return (op == c_OP_ANDI) || (op == c_OP_ORI);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wait_timer
//  Description : Counts non-ready memory cycles and flags a bus timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic CLK,
    input  logic rst,
    input  logic i_active,
    input  logic i_ready,
    output logic o_timeout
);

    localparam logic [7:0] c_WAIT_MAX = 8'(WAIT_MAX);

    logic [7:0] r_cnt;
    logic       w_stall;

    assign o_timeout = i_active & ~i_ready & (r_cnt == c_WAIT_MAX);
    assign w_stall   = i_active & ~i_ready & ~o_timeout;

    // Completion, timeout or leaving a wait state all land in a fresh state,
    // so clearing whenever not stalling gives a zero count on every entry.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_stall) begin
            r_cnt <= r_cnt + 8'd1;
        end else begin
            r_cnt <= '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl_fsm
//  Description : Multicycle MIPS-style control FSM with memory timeout,
//                illegal-opcode trap and retired-instruction counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 32,
    parameter int EN_EXT   = 1
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic [5:0]       Op,
    input  logic             MemReady,
    output logic             MemReq,
    output logic             IorD,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             Branch,
    output logic             BranchNe,
    output logic [1:0]       PCSrc,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic             ImmZero,
    output logic             RegWrite,
    output logic [1:0]       RegDst,
    output logic [1:0]       MemtoReg,
    output logic             Illegal,
    output logic             BusErr,
    output logic [CNT_W-1:0] Retired
);

    logic [3:0]       r_state;
    logic [3:0]       w_next;
    logic [5:0]       r_op;
    logic [CNT_W-1:0] r_retired;
    logic             w_wait_state;
    logic             w_timeout;
    logic             w_retire;

    assign w_wait_state = (r_state == c_ST_FETCH) || (r_state == c_ST_MEMRD) ||
                          (r_state == c_ST_MEMWR);

    mem_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait (
        .CLK       (CLK),
        .rst       (rst),
        .i_active  (w_wait_state),
        .i_ready   (MemReady),
        .o_timeout (w_timeout)
    );

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            r_state   <= c_ST_FETCH;
            r_op      <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == c_ST_DECODE) begin
                r_op <= Op;
            end
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    assign Retired = r_retired;

    always_comb begin
        w_next   = r_state;
        w_retire = 1'b0;
        MemReq   = 1'b0;
        IorD     = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        Branch   = 1'b0;
        BranchNe = 1'b0;
        PCSrc    = c_PCSRC_ALU;
        ALUSrcA  = 1'b0;
        ALUSrcB  = c_SRCB_RT;
        ALUOp    = c_ALUOP_ADD;
        ImmZero  = 1'b0;
        RegWrite = 1'b0;
        RegDst   = c_REGDST_RT;
        MemtoReg = c_MEMTOREG_ALU;
        Illegal  = 1'b0;
        BusErr   = w_timeout;

        case (r_state)
            c_ST_FETCH: begin
                MemReq  = 1'b1;
                ALUSrcB = c_SRCB_FOUR;
                // Strobes are gated by rst so reset shows FETCH values without writes.
                IRWrite = MemReady & rst;
                PCWrite = MemReady & rst;
                if (MemReady) begin
                    w_next = c_ST_DECODE;
                end else if (w_timeout) begin
                    w_next = c_ST_FETCH;
                end
            end
            c_ST_DECODE: begin
                ALUSrcB = c_SRCB_IMM_SL2;
                case (Op)
                    c_OP_LW, c_OP_SW: w_next = c_ST_MEMADR;
                    c_OP_RTYPE:       w_next = c_ST_EXEC;
                    c_OP_BEQ:         w_next = c_ST_BRANCH;
                    c_OP_ADDI:        w_next = c_ST_IEXEC;
                    c_OP_J:           w_next = c_ST_JUMP;
                    c_OP_ANDI, c_OP_ORI, c_OP_SLTI:
                        w_next = (EN_EXT != 0) ? c_ST_IEXEC : c_ST_TRAP;
                    c_OP_BNE:         w_next = (EN_EXT != 0) ? c_ST_BRANCH : c_ST_TRAP;
                    c_OP_JAL:         w_next = (EN_EXT != 0) ? c_ST_JAL : c_ST_TRAP;
                    default:          w_next = c_ST_TRAP;
                endcase
            end
            c_ST_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = c_SRCB_IMM;
                w_next  = (r_op == c_OP_SW) ? c_ST_MEMWR : c_ST_MEMRD;
            end
            c_ST_MEMRD: begin
                MemReq = 1'b1;
                IorD   = 1'b1;
                if (MemReady) begin
                    w_next = c_ST_MEMWB;
                end else if (w_timeout) begin
                    w_next = c_ST_FETCH;
                end
            end
            c_ST_MEMWB: begin
                RegWrite = rst;
                MemtoReg = c_MEMTOREG_MEM;
                w_retire = 1'b1;
                w_next   = c_ST_FETCH;
            end
            c_ST_MEMWR: begin
                MemReq   = 1'b1;
                IorD     = 1'b1;
                MemWrite = MemReady & rst;
                if (MemReady) begin
                    w_retire = 1'b1;
                    w_next   = c_ST_FETCH;
                end else if (w_timeout) begin
                    w_next = c_ST_FETCH;
                end
            end
            c_ST_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = c_ALUOP_FUNCT;
                w_next  = c_ST_ALUWB;
            end
            c_ST_ALUWB: begin
                RegWrite = rst;
                RegDst   = c_REGDST_RD;
                w_retire = 1'b1;
                w_next   = c_ST_FETCH;
            end
            c_ST_BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = c_ALUOP_SUB;
                PCSrc    = c_PCSRC_ALUOUT;
                Branch   = (r_op == c_OP_BEQ);
                BranchNe = (r_op == c_OP_BNE);
                w_retire = 1'b1;
                w_next   = c_ST_FETCH;
            end
            c_ST_IEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = c_SRCB_IMM;
                ALUOp   = (r_op == c_OP_ADDI) ? c_ALUOP_ADD : c_ALUOP_IMM;
                ImmZero = is_zext_op(r_op);
                w_next  = c_ST_IWB;
            end
            c_ST_IWB: begin
                ImmZero  = is_zext_op(r_op);
                RegWrite = rst;
                w_retire = 1'b1;
                w_next   = c_ST_FETCH;
            end
            c_ST_JUMP: begin
                PCSrc    = c_PCSRC_JUMP;
                PCWrite  = rst;
                w_retire = 1'b1;
                w_next   = c_ST_FETCH;
            end
            c_ST_JAL: begin
                PCSrc    = c_PCSRC_JUMP;
                PCWrite  = rst;
                RegWrite = rst;
                RegDst   = c_REGDST_RA;
                MemtoReg = c_MEMTOREG_PC;
                w_retire = 1'b1;
                w_next   = c_ST_FETCH;
            end
            c_ST_TRAP: begin
                Illegal = 1'b1;
                w_next  = c_ST_FETCH;
            end
            default: begin
                w_next = c_ST_FETCH;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_ctrl_fsm
//  Description : Directed bench; dut_a has extensions on, dut_b off, both
//                share stimulus and stay cycle-aligned.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl_fsm;

    logic        CLK;
    logic        rst;
    logic [5:0]  Op;
    logic        MemReady;

    logic        MemReq, IorD, MemWrite, IRWrite, PCWrite, Branch, BranchNe;
    logic [1:0]  PCSrc, ALUSrcB, ALUOp, RegDst, MemtoReg;
    logic        ALUSrcA, ImmZero, RegWrite, Illegal, BusErr;
    logic [31:0] Retired;

    logic        b_MemReq, b_IorD, b_MemWrite, b_IRWrite, b_PCWrite, b_Branch, b_BranchNe;
    logic [1:0]  b_PCSrc, b_ALUSrcB, b_ALUOp, b_RegDst, b_MemtoReg;
    logic        b_ALUSrcA, b_ImmZero, b_RegWrite, b_Illegal, b_BusErr;
    logic [31:0] b_Retired;

    int n_checks;
    int n_errors;

    multicycle_ctrl_fsm #(.WAIT_MAX(4), .CNT_W(32), .EN_EXT(1)) dut_a (
        .CLK(CLK), .rst(rst), .Op(Op), .MemReady(MemReady),
        .MemReq(MemReq), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .Branch(Branch), .BranchNe(BranchNe), .PCSrc(PCSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmZero(ImmZero),
        .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .Illegal(Illegal), .BusErr(BusErr), .Retired(Retired)
    );

    multicycle_ctrl_fsm #(.WAIT_MAX(4), .CNT_W(32), .EN_EXT(0)) dut_b (
        .CLK(CLK), .rst(rst), .Op(Op), .MemReady(MemReady),
        .MemReq(b_MemReq), .IorD(b_IorD), .MemWrite(b_MemWrite), .IRWrite(b_IRWrite),
        .PCWrite(b_PCWrite), .Branch(b_Branch), .BranchNe(b_BranchNe), .PCSrc(b_PCSrc),
        .ALUSrcA(b_ALUSrcA), .ALUSrcB(b_ALUSrcB), .ALUOp(b_ALUOp), .ImmZero(b_ImmZero),
        .RegWrite(b_RegWrite), .RegDst(b_RegDst), .MemtoReg(b_MemtoReg),
        .Illegal(b_Illegal), .BusErr(b_BusErr), .Retired(b_Retired)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b0;
        MemReady = 1'b1;
        Op       = 6'b000000;

        // Reset: FETCH values with write strobes held off
        @(negedge CLK); #1;
        check("rst_memreq", MemReq, 1);
        check("rst_irwrite", IRWrite, 0);
        check("rst_pcwrite", PCWrite, 0);
        check("rst_srcb", ALUSrcB, 2'b01);
        check("rst_retired", Retired, 0);
        @(negedge CLK);
        rst = 1'b1;

        // lw with MemReady always high; Op disturbed after DECODE
        Op = 6'b100011; #1;
        check("lw_f_irwrite", IRWrite, 1);
        check("lw_f_pcwrite", PCWrite, 1);
        @(negedge CLK); #1;
        check("lw_d_srcb", ALUSrcB, 2'b11);
        check("lw_d_memreq", MemReq, 0);
        @(negedge CLK);
        Op = 6'b000000; #1;
        check("lw_ma_srca", ALUSrcA, 1);
        check("lw_ma_srcb", ALUSrcB, 2'b10);
        @(negedge CLK); #1;
        check("lw_rd_memreq", MemReq, 1);
        check("lw_rd_iord", IorD, 1);
        @(negedge CLK); #1;
        check("lw_wb_regwrite", RegWrite, 1);
        check("lw_wb_memtoreg", MemtoReg, 2'b01);
        check("lw_wb_retired", Retired, 0);
        @(negedge CLK);

        // Fetch with 3 not-ready cycles, then sw that times out
        MemReady = 1'b0;
        Op = 6'b101011; #1;
        check("lw_done_retired", Retired, 1);
        for (int i = 0; i < 3; i++) begin
            check("fw_irwrite", IRWrite, 0);
            check("fw_pcwrite", PCWrite, 0);
            @(negedge CLK); #1;
        end
        MemReady = 1'b1; #1;
        check("fw_irwrite_go", IRWrite, 1);
        check("fw_pcwrite_go", PCWrite, 1);
        @(negedge CLK);
        @(negedge CLK);
        MemReady = 1'b0;
        @(negedge CLK); #1;
        for (int i = 0; i < 4; i++) begin
            check("sw_wait_memwrite", MemWrite, 0);
            check("sw_wait_buserr", BusErr, 0);
            @(negedge CLK); #1;
        end
        check("sw_to_buserr", BusErr, 1);
        check("sw_to_memwrite", MemWrite, 0);
        @(negedge CLK);

        // Illegal opcode on both instances
        MemReady = 1'b1;
        Op = 6'b111111; #1;
        check("to_fetch_buserr", BusErr, 0);
        check("to_fetch_iord", IorD, 0);
        check("to_fetch_memreq", MemReq, 1);
        check("to_retired", Retired, 1);
        @(negedge CLK);
        @(negedge CLK); #1;
        check("trap_illegal_a", Illegal, 1);
        check("trap_illegal_b", b_Illegal, 1);
        check("trap_regwrite", RegWrite, 0);
        @(negedge CLK);

        // bne: BRANCH on dut_a, TRAP on dut_b
        Op = 6'b000101; #1;
        check("trap_after_illegal", Illegal, 0);
        check("trap_retired", Retired, 1);
        @(negedge CLK);
        @(negedge CLK); #1;
        check("bne_branchne", BranchNe, 1);
        check("bne_branch", Branch, 0);
        check("bne_pcsrc", PCSrc, 2'b01);
        check("bne_aluop", ALUOp, 2'b01);
        check("bne_b_illegal", b_Illegal, 1);
        @(negedge CLK);

        // jal
        Op = 6'b000011; #1;
        check("bne_retired", Retired, 2);
        check("bne_b_retired", b_Retired, 1);
        @(negedge CLK);
        @(negedge CLK); #1;
        check("jal_pcwrite", PCWrite, 1);
        check("jal_regwrite", RegWrite, 1);
        check("jal_regdst", RegDst, 2'b10);
        check("jal_memtoreg", MemtoReg, 2'b10);
        check("jal_pcsrc", PCSrc, 2'b10);
        check("jal_b_illegal", b_Illegal, 1);
        @(negedge CLK);

        // ori; dut_b idles one FETCH cycle while dut_a is in IWB
        Op = 6'b001101; #1;
        check("jal_retired", Retired, 3);
        @(negedge CLK);
        @(negedge CLK); #1;
        check("ori_immzero", ImmZero, 1);
        check("ori_aluop", ALUOp, 2'b11);
        check("ori_srcb", ALUSrcB, 2'b10);
        check("ori_b_illegal", b_Illegal, 1);
        @(negedge CLK);
        MemReady = 1'b0; #1;
        check("ori_wb_regwrite", RegWrite, 1);
        check("ori_wb_immzero", ImmZero, 1);
        check("ori_wb_regdst", RegDst, 2'b00);
        @(negedge CLK);

        // addi on both instances
        MemReady = 1'b1;
        Op = 6'b001000; #1;
        check("ori_retired", Retired, 4);
        @(negedge CLK);
        @(negedge CLK); #1;
        check("addi_aluop", ALUOp, 2'b00);
        check("addi_immzero", ImmZero, 0);
        @(negedge CLK);
        @(negedge CLK);

        // lw interrupted by reset during MEMRD
        Op = 6'b100011; #1;
        check("addi_retired", Retired, 5);
        check("addi_b_retired", b_Retired, 2);
        @(negedge CLK);
        @(negedge CLK);
        MemReady = 1'b0;
        @(negedge CLK); #1;
        check("mrd_iord", IorD, 1);
        @(negedge CLK);
        rst = 1'b0;
        MemReady = 1'b1; #1;
        check("mrst_memreq", MemReq, 1);
        check("mrst_iord", IorD, 0);
        check("mrst_srcb", ALUSrcB, 2'b01);
        check("mrst_irwrite", IRWrite, 0);
        check("mrst_regwrite", RegWrite, 0);
        check("mrst_retired", Retired, 0);
        @(negedge CLK);
        rst = 1'b1; #1;
        check("mrst_fetch_irwrite", IRWrite, 1);
        @(negedge CLK); #1;
        check("mrst_decode_memreq", MemReq, 0);
        check("mrst_decode_srcb", ALUSrcB, 2'b11);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
